// File: rtl/life_flow_pkg.sv
// life_flow_pkg: shared state, cause and frame constants for the death flow.
// States are one-hot; S_* give the bit index of each state.
package life_flow_pkg;

    localparam int S_PLAY      = 0;
    localparam int S_DYING     = 1;
    localparam int S_RESPAWN   = 2;
    localparam int S_INVULN    = 3;
    localparam int S_GAME_OVER = 4;

    typedef enum logic [4:0] {
        PLAY      = 5'b00001,
        DYING     = 5'b00010,
        RESPAWN   = 5'b00100,
        INVULN    = 5'b01000,
        GAME_OVER = 5'b10000
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_ENEMY = 2'd1,
        CAUSE_PIT   = 2'd2,
        CAUSE_TIME  = 2'd3
    } cause_t;

    localparam int DEF_DEATH_FRAMES  = 60;
    localparam int DEF_INVULN_FRAMES = 120;
    localparam int DEF_CNT_W         = 8;

    function automatic cause_t pick_cause(input logic pit, input logic tup);
        if (pit) return CAUSE_PIT;
        if (tup) return CAUSE_TIME;
        return CAUSE_ENEMY;
    endfunction

endpackage

// File: rtl/life_flow_controller_if.sv
// life_flow_controller_if: hazard inputs and flow outputs of the controller.
// LIFE_FLOW_CONTINUE_EN adds start_btn and lives_reset_n.
interface life_flow_controller_if;

    logic       frame_tick;
    logic       hit_enemy;
    logic       fall_pit;
    logic       time_up;
    int         lives;
    logic       kill;
    logic       freeze;
    logic       respawn;
    logic       invulnerable;
    logic       game_over;
    logic [1:0] death_cause;
`ifdef LIFE_FLOW_CONTINUE_EN
    logic       start_btn;
    logic       lives_reset_n;

    modport master (
        input  frame_tick, hit_enemy, fall_pit, time_up, lives, start_btn,
        output kill, freeze, respawn, invulnerable, game_over, death_cause,
        output lives_reset_n
    );
    modport slave (
        output frame_tick, hit_enemy, fall_pit, time_up, lives, start_btn,
        input  kill, freeze, respawn, invulnerable, game_over, death_cause,
        input  lives_reset_n
    );
`else
    modport master (
        input  frame_tick, hit_enemy, fall_pit, time_up, lives,
        output kill, freeze, respawn, invulnerable, game_over, death_cause
    );
    modport slave (
        output frame_tick, hit_enemy, fall_pit, time_up, lives,
        input  kill, freeze, respawn, invulnerable, game_over, death_cause
    );
`endif

endinterface

// File: rtl/life_flow_controller_frame_timer.sv
// frame_timer: saturating frame counter with clear, tick enable and a
// terminal flag raised on the tick that brings the count up to limit.
module frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             last
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             step;

    assign step    = en & tick & ~(&cnt);
    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
    assign last    = step & (cnt_inc == {1'b0, limit});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt_inc[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/life_flow_controller.sv
// life_flow_controller: one kill per life, death freeze, respawn grace window
// and game over. LIFE_FLOW_CONTINUE_EN lets start_btn continue from game over.
module life_flow_controller
    import life_flow_pkg::*;
#(
    parameter int DEATH_FRAMES  = DEF_DEATH_FRAMES,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input logic                    vga_clock,
    input logic                    reset,
    life_flow_controller_if.master bus
);

    state_t           state, state_nx;
    cause_t           cause_q, cause_d;
    logic             hit, cont;
    logic             tmr_last, tmr_en, tmr_clr;
    logic [CNT_W-1:0] tmr_limit;
    logic             kill_q, freeze_q, respawn_q, invuln_q, over_q;
    logic             kill_d, freeze_d, respawn_d, invuln_d, over_d;

    // Enemy contact only counts while fully vulnerable.
    assign hit = bus.fall_pit | bus.time_up
               | (bus.hit_enemy & state[S_PLAY]);

    assign tmr_en    = state[S_DYING] | state[S_INVULN];
    assign tmr_clr   = (state_nx != state);
    assign tmr_limit = state[S_DYING] ? CNT_W'(DEATH_FRAMES)
                                      : CNT_W'(INVULN_FRAMES);

    frame_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (vga_clock),
        .rst_n (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tick  (bus.frame_tick),
        .limit (tmr_limit),
        .last  (tmr_last)
    );

`ifdef LIFE_FLOW_CONTINUE_EN
    logic start_q, lrn_q;

    assign cont = state[S_GAME_OVER] & bus.start_btn & ~start_q;

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b0;
            lrn_q   <= 1'b1;
        end else begin
            start_q <= bus.start_btn;
            lrn_q   <= ~cont;
        end
    end

    assign bus.lives_reset_n = lrn_q;
`else
    assign cont = 1'b0;
`endif

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state     <= PLAY;
            kill_q    <= 1'b0;
            freeze_q  <= 1'b0;
            respawn_q <= 1'b0;
            invuln_q  <= 1'b0;
            over_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state     <= state_nx;
            kill_q    <= kill_d;
            freeze_q  <= freeze_d;
            respawn_q <= respawn_d;
            invuln_q  <= invuln_d;
            over_q    <= over_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            state[S_PLAY]: begin
                if (hit) state_nx = DYING;
            end
            state[S_DYING]: begin
                if (tmr_last)
                    state_nx = (bus.lives == 0) ? GAME_OVER : RESPAWN;
            end
            state[S_RESPAWN]: begin
                state_nx = INVULN;
            end
            state[S_INVULN]: begin
                if (hit)           state_nx = DYING;
                else if (tmr_last) state_nx = PLAY;
            end
            state[S_GAME_OVER]: begin
                if (cont) state_nx = RESPAWN;
            end
            default: state_nx = PLAY;
        endcase
    end

    // Outputs are registered from the state being entered.
    always_comb begin
        kill_d    = state_nx[S_DYING] & ~state[S_DYING];
        freeze_d  = state_nx[S_DYING] | state_nx[S_GAME_OVER];
        respawn_d = state_nx[S_RESPAWN];
        invuln_d  = state_nx[S_RESPAWN] | state_nx[S_INVULN];
        over_d    = state_nx[S_GAME_OVER];
        cause_d   = cause_q;
        if (kill_d)
            cause_d = pick_cause(bus.fall_pit, bus.time_up);
        else if (respawn_d)
            cause_d = CAUSE_NONE;
    end

    assign bus.kill         = kill_q;
    assign bus.freeze       = freeze_q;
    assign bus.respawn      = respawn_q;
    assign bus.invulnerable = invuln_q;
    assign bus.game_over    = over_q;
    assign bus.death_cause  = cause_q;

endmodule
